// File: rtl/npu_stream_pkg.sv
// Shared types and constants for the npu pixel stream path.
// Holds the transmitter FSM encoding, pipeline depth and default geometry.
package npu_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } tx_state_t;

    // Cycles from rd_en to the matching pixel on the output
    localparam int PIPE_LAT = 2;

    // Default geometry shared with memory_stage
    localparam int DEF_IMG_W = 32;
    localparam int DEF_IMG_H = 32;
    localparam int PIX_W     = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pixel_timing_counter.sv
// Column, row and blanking counters for the pixel stream transmitter.
// Provides terminal-count flags so the FSM never compares raw counts.
module pixel_timing_counter
    import npu_stream_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int H_BLANK = 8,
    parameter int V_BLANK = 16,
    parameter int COL_W   = $clog2(IMG_W),
    parameter int ROW_W   = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             col_inc,
    input  logic             row_inc,
    input  logic             frame_clr,
    input  logic             blank_en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             col_last,
    output logic             row_last,
    output logic             hb_last,
    output logic             vb_last
);

    localparam int BLK_W = $clog2(max2(H_BLANK, V_BLANK) + 1);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
    localparam logic [BLK_W-1:0] HB_MAX  = BLK_W'(H_BLANK - 1);
    localparam logic [BLK_W-1:0] VB_MAX  = BLK_W'(V_BLANK - 1);

    logic [BLK_W-1:0] blank;

    // Column counter, wraps to 0 after the last active pixel of a row
    always_ff @(posedge clk) begin
        if (reset || frame_clr) begin
            col <= '0;
        end else if (col_inc) begin
            col <= col_last ? '0 : col + 1'b1;
        end
    end

    // Row counter, advanced at the end of each horizontal blank
    always_ff @(posedge clk) begin
        if (reset || frame_clr) begin
            row <= '0;
        end else if (row_inc) begin
            row <= row + 1'b1;
        end
    end

    // Blank counter, runs only while in a blanking state
    always_ff @(posedge clk) begin
        if (reset || !blank_en) begin
            blank <= '0;
        end else begin
            blank <= blank + 1'b1;
        end
    end

    // Terminal-count flags
    always_comb begin
        col_last = (col == COL_MAX);
        row_last = (row == ROW_MAX);
        hb_last  = (blank == HB_MAX);
        vb_last  = (blank == VB_MAX);
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame transmitter: reads a greyscale frame from memory and emits
// it as an 8-bit pixel stream with de, sof and eol and blanking.
module pixel_stream_tx
    import npu_stream_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int H_BLANK = 8,
    parameter int V_BLANK = 16,
    parameter int ADDR_W  = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              loop_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              de_out,
    output logic [PIX_W-1:0]  data_out,
    output logic              sof_out,
    output logic              eol_out,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    tx_state_t state;
    tx_state_t next_state;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last;
    logic             row_last;
    logic             hb_last;
    logic             vb_last;

    logic col_inc;
    logic row_inc;
    logic frame_clr;
    logic blank_en;
    logic sof_flag;
    logic eol_flag;

    logic [PIPE_LAT-1:0] de_pipe;
    logic [PIPE_LAT-1:0] sof_pipe;
    logic [PIPE_LAT-1:0] eol_pipe;

    pixel_timing_counter #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .col_inc   (col_inc),
        .row_inc   (row_inc),
        .frame_clr (frame_clr),
        .blank_en  (blank_en),
        .col       (col),
        .row       (row),
        .col_last  (col_last),
        .row_last  (row_last),
        .hb_last   (hb_last),
        .vb_last   (vb_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) next_state = ACTIVE;
            end
            ACTIVE: begin
                if (col_last) begin
                    next_state = row_last ? VBLANK : HBLANK;
                end
            end
            HBLANK: begin
                if (hb_last) next_state = ACTIVE;
            end
            VBLANK: begin
                if (vb_last) begin
                    next_state = loop_en ? ACTIVE : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Memory strobe, address and counter controls from current state
    always_comb begin
        rd_en     = (state == ACTIVE);
        rd_addr   = ADDR_W'(int'(row) * IMG_W + int'(col));
        col_inc   = (state == ACTIVE);
        row_inc   = (state == HBLANK) && hb_last;
        frame_clr = (state == VBLANK) && vb_last;
        blank_en  = (state == HBLANK) || (state == VBLANK);
        sof_flag  = rd_en && (row == '0) && (col == '0);
        eol_flag  = rd_en && col_last;
    end

    // Registered status: busy follows the next state, done marks VBLANK exit
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (state == VBLANK) && vb_last;
        end
    end

    // Flag pipeline matching the memory read latency plus output capture
    always_ff @(posedge clk) begin
        if (reset) begin
            de_pipe  <= '0;
            sof_pipe <= '0;
            eol_pipe <= '0;
        end else begin
            de_pipe  <= {de_pipe[PIPE_LAT-2:0], rd_en};
            sof_pipe <= {sof_pipe[PIPE_LAT-2:0], sof_flag};
            eol_pipe <= {eol_pipe[PIPE_LAT-2:0], eol_flag};
        end
    end

    // Pixel capture, zero whenever the pixel is not valid
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= de_pipe[PIPE_LAT-2] ? rd_data : '0;
        end
    end

    assign de_out  = de_pipe[PIPE_LAT-1];
    assign sof_out = sof_pipe[PIPE_LAT-1];
    assign eol_out = eol_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx using a frame-level timing model.
// Expected waveforms are built from frame geometry, then compared per cycle.
module tb_pixel_stream_tx;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int HB   = 2;
    localparam int VB   = 3;
    localparam int AW   = $clog2(W * H);
    localparam int NPIX = W * H;
    localparam int FLEN = W * H + (H - 1) * HB + VB;
    localparam int MAXC = 220;
    localparam int LEN  = MAXC + FLEN + 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          loop_en = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          de_out;
    logic [7:0]    data_out;
    logic          sof_out;
    logic          eol_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [NPIX];

    bit st_v [MAXC];
    bit lp_v [MAXC];
    bit rs_v [MAXC];

    bit e_rd   [LEN];
    bit e_de   [LEN];
    bit e_sof  [LEN];
    bit e_eol  [LEN];
    bit e_busy [LEN];
    bit e_done [LEN];
    int e_addr [LEN];
    int e_data [LEN];

    pixel_stream_tx #(
        .IMG_W   (W),
        .IMG_H   (H),
        .H_BLANK (HB),
        .V_BLANK (VB),
        .ADDR_W  (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .loop_en  (loop_en),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .de_out   (de_out),
        .data_out (data_out),
        .sof_out  (sof_out),
        .eol_out  (eol_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous frame memory, one cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stim();
        for (int k = 0; k < MAXC; k++) begin
            st_v[k] = 1'b0;
            lp_v[k] = 1'b0;
            rs_v[k] = 1'b0;
        end
    endtask

    task automatic clr_exp_from(input int j0);
        for (int j = j0; j < LEN; j++) begin
            e_rd[j]   = 1'b0;
            e_de[j]   = 1'b0;
            e_sof[j]  = 1'b0;
            e_eol[j]  = 1'b0;
            e_busy[j] = 1'b0;
            e_done[j] = 1'b0;
            e_addr[j] = 0;
            e_data[j] = 0;
        end
    endtask

    // One frame whose first memory read happens in cycle s
    task automatic sched(input int s);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int t;
                t = s + r * (W + HB) + c;
                e_rd[t]     = 1'b1;
                e_addr[t]   = r * W + c;
                e_de[t+2]   = 1'b1;
                e_data[t+2] = int'(mem[r * W + c]);
                e_sof[t+2]  = (r == 0) && (c == 0);
                e_eol[t+2]  = (c == W - 1);
            end
        end
        for (int t = s; t < s + FLEN; t++) e_busy[t] = 1'b1;
        e_done[s + FLEN] = 1'b1;
    endtask

    // Frame-level model: accepted starts, looping, and reset aborts
    task automatic build(input int n);
        bit act;
        int d;
        act = 1'b0;
        d = 0;
        clr_exp_from(0);
        for (int k = 0; k < n; k++) begin
            if (rs_v[k]) begin
                clr_exp_from(k + 1);
                act = 1'b0;
            end else if (act && k == d - 1) begin
                if (lp_v[k]) begin
                    sched(d);
                    d = d + FLEN;
                end
            end else if ((!act || k >= d) && st_v[k]) begin
                sched(k + 1);
                act = 1'b1;
                d = k + 1 + FLEN;
            end
        end
    endtask

    task automatic run(input string name, input int n);
        build(n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            start   = st_v[k];
            loop_en = lp_v[k];
            reset   = rs_v[k];
            @(negedge clk);
            chk($sformatf("%s rd_en@%0d", name, k), 32'(rd_en), 32'(e_rd[k]));
            if (e_rd[k]) begin
                chk($sformatf("%s rd_addr@%0d", name, k),
                    32'(rd_addr), 32'(e_addr[k]));
            end
            chk($sformatf("%s de@%0d", name, k), 32'(de_out), 32'(e_de[k]));
            chk($sformatf("%s data@%0d", name, k),
                32'(data_out), 32'(e_data[k]));
            chk($sformatf("%s sof@%0d", name, k), 32'(sof_out), 32'(e_sof[k]));
            chk($sformatf("%s eol@%0d", name, k), 32'(eol_out), 32'(e_eol[k]));
            chk($sformatf("%s busy@%0d", name, k), 32'(busy), 32'(e_busy[k]));
            chk($sformatf("%s done@%0d", name, k), 32'(done), 32'(e_done[k]));
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rd_en", 32'(rd_en), 32'd0);
        chk("reset de", 32'(de_out), 32'd0);
        chk("reset data", 32'(data_out), 32'd0);
        chk("reset sof", 32'(sof_out), 32'd0);
        chk("reset eol", 32'(eol_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset addr", 32'(rd_addr), 32'd0);
        reset = 1'b0;

        // Single frame, address-valued memory, ignored start in cycle 8
        clr_stim();
        st_v[0] = 1'b1;
        st_v[8] = 1'b1;
        run("single", 28);

        // Looped frame: loop_en seen at end of first VBLANK only
        clr_stim();
        st_v[0] = 1'b1;
        for (int k = 0; k < 20; k++) lp_v[k] = 1'b1;
        run("loop", 46);

        // Reset mid-row, then restart
        clr_stim();
        st_v[0]  = 1'b1;
        rs_v[10] = 1'b1;
        st_v[12] = 1'b1;
        run("abort", 40);

        // start and reset together: reset wins
        clr_stim();
        st_v[0] = 1'b1;
        rs_v[0] = 1'b1;
        run("strst", 6);

        // Randomized memory contents, starts, loop and resets
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(255));
            clr_stim();
            for (int k = 0; k < 160; k++) begin
                st_v[k] = ($urandom_range(7) == 0);
                lp_v[k] = 1'($urandom_range(1));
                rs_v[k] = ($urandom_range(63) == 0);
            end
            run($sformatf("rand%0d", it), 200);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
Frame transmitter feeding the npu pixel input interface (de_in / data_in).
- Reads one greyscale frame, row-major, from a synchronous frame memory.
- Emits the frame as an 8-bit pixel stream with de high during active pixels, horizontal blanking between rows and vertical blanking after the frame.
- Used as the on-chip source in front of the npu and as the stimulus driver in system benches.

Parameters:
IMG_W, 32, active pixels per row (>=2)
IMG_H, 32, rows per frame (>=2)
H_BLANK, 8, de-low cycles between rows (>=1)
V_BLANK, 16, de-low cycles after last row before done (>=2, covers output pipeline drain)
ADDR_W, $clog2(IMG_W*IMG_H), frame memory address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to send one frame; ignored while busy
loop_en  in  1  sampled at end of V_BLANK; 1 = restart next frame immediately
rd_en  out  1  frame memory read strobe
rd_addr  out  ADDR_W  frame memory address, row*IMG_W+col
rd_data  in  8  memory data, valid the cycle after rd_en
de_out  out  1  pixel valid, drives npu de_in
data_out  out  8  pixel value, drives npu data_in; 0 when de_out low
sof_out  out  1  high with the first pixel of each frame
eol_out  out  1  high with the last pixel of each row
busy  out  1  high from the cycle after accepted start until the end of V_BLANK
done  out  1  single-cycle pulse when a frame, including V_BLANK, completes

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared. Reset mid-frame aborts immediately; no done pulse; the pipeline is flushed so de_out is 0 on the cycle after reset.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
  - IDLE -> ACTIVE when start=1 (sampled at the clock edge).
  - ACTIVE: rd_en=1, col increments 0..IMG_W-1. At col=IMG_W-1 go to HBLANK if row<IMG_H-1, else go to VBLANK.
  - HBLANK: H_BLANK cycles with rd_en=0, then row+1, col=0, return to ACTIVE.
  - VBLANK: V_BLANK cycles. On the last cycle:
    - loop_en=1: next state ACTIVE, row=col=0, done still pulses, busy stays 1.
    - loop_en=0: next state IDLE.
  - No HBLANK after the last row.
- busy = (state != IDLE), registered. done pulses in the cycle the FSM leaves VBLANK.
- rd_addr is driven from registered row/col; it wraps to 0 only at frame restart.
- Output pipeline is fixed at 2 cycles from rd_en:
  - rd_data is captured into data_out the cycle after rd_data is valid.
  - de_out, sof_out and eol_out are rd_en, first-pixel and last-col flags delayed by 2 cycles.
  - First pixel of a frame appears on the output 3 cycles after the start cycle.
- Frame length from first rd_en to done: IMG_H*IMG_W + (IMG_H-1)*H_BLANK + V_BLANK cycles.
- start during busy has no effect, and is not queued.
- start in the same cycle as reset: reset wins.
- data_out is forced to 0 whenever de_out=0.

Decomposition:
- Package npu_stream_pkg holds:
  - tx_state_t enum (IDLE, ACTIVE, HBLANK, VBLANK)
  - PIPE_LAT=2 constant
  - default geometry constants shared with memory_stage (image width, pixel width 8)
- One sub-module, pixel_timing_counter: col/row/blank counters with wrap and terminal-count flags. The FSM and output pipe live in pixel_stream_tx.

Test Plan:
- IMG_W=4, IMG_H=3, H_BLANK=2, V_BLANK=3; memory holds addr value; start in cycle 0:
  - rd_en in cycles 1-4, 7-10, 13-16.
  - de_out in cycles 3-6, 9-12, 15-18 with data 0..11.
  - sof_out in cycle 3; eol_out in cycles 6, 12, 18.
  - busy in cycles 1-19; done in cycle 20.
- Same configuration, second start pulse in cycle 8 -> ignored; identical waveform; a single done in cycle 20.
- Same configuration with loop_en=1 -> second frame rd_en from cycle 20, sof_out in cycle 22, done pulses in cycles 20 and 39, busy never drops.
- Reset asserted in cycle 10 mid-row -> cycle 11: de_out=0, busy=0, rd_en=0, no done. A new start in cycle 12 gives first pixel data 0 in cycle 15.
- Default parameters with an npu connected and the memory holding a test image -> exactly 1024 de_out cycles per frame, 32 eol_out pulses, 31 gaps of 8 cycles; npu symbol outputs match the golden model.
- start and reset high together in cycle 0 -> state stays IDLE, busy=0 in cycle 1, no rd_en.
